// File: rtl/vga_bram_arbiter_if.sv
// Bundle between the VGA scanout, the cover-art/UI loader and BRAM port B.
// The master side drives the requests and doutb. The slave side (the arbiter) drives everything else.
interface vga_bram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    // Handshake: vga_req has no back-pressure and is accepted on every edge where it is high.
    // ld_req stays stable until ld_gnt is seen, and a loader transfer happens on any edge with ld_req & ld_gnt.
    // Each rvalid is a 1-cycle pulse, and there is no ready signal on the return path.
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_starve;
    logic [ADDR_W-1:0] addrb;
    logic              web;
    logic [DATA_W-1:0] dinb;
    logic [DATA_W-1:0] doutb;

    modport master (
        output vga_req, vga_addr, ld_req, ld_we, ld_addr, ld_wdata, doutb,
        input  vga_rvalid, vga_rdata, ld_gnt, ld_rvalid, ld_rdata, ld_starve,
               addrb, web, dinb
    );

    modport slave (
        input  vga_req, vga_addr, ld_req, ld_we, ld_addr, ld_wdata, doutb,
        output vga_rvalid, vga_rdata, ld_gnt, ld_rvalid, ld_rdata, ld_starve,
               addrb, web, dinb
    );
endinterface

// File: rtl/vga_bram_arbiter.sv
// Fixed-priority share of BRAM port B: VGA scanout first, then loader, with read-return tagging.
// Defining ARB_STATS_EN adds the 32-bit stat_ld_grants and stat_ld_denied counters.
module vga_bram_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 200
) (
    input  logic              CLK,
    input  logic              RST_BTN,
    vga_bram_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       stat_ld_grants,
    output logic [31:0]       stat_ld_denied
`endif
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_LD   = 2'd2
    } tag_t;

    localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;
    localparam logic [31:0]       MAX_WAIT_U = 32'(MAX_WAIT);

    logic              w_vga_gnt;
    logic              w_ld_gnt;
    logic              w_ld_wait;
    tag_t              w_tag_in;
    logic [WAIT_W-1:0] w_wait_nxt;

    logic [ADDR_W-1:0] r_addrb;
    logic              r_web;
    logic [DATA_W-1:0] r_dinb;
    tag_t              r_tag [0:RD_LAT];
    logic              r_vga_rvalid;
    logic [DATA_W-1:0] r_vga_rdata;
    logic              r_ld_rvalid;
    logic [DATA_W-1:0] r_ld_rdata;
    logic [WAIT_W-1:0] r_wait;
    logic              r_starve;

    assign w_vga_gnt = bus.vga_req;
    assign w_ld_gnt  = bus.ld_req & ~bus.vga_req;
    assign w_ld_wait = bus.ld_req & bus.vga_req;

    // Only reads get a tag. Loader writes and idle cycles send TAG_NONE down the pipe.
    always_comb begin
        w_tag_in = TAG_NONE;
        if (w_vga_gnt) begin
            w_tag_in = TAG_VGA;
        end else if (w_ld_gnt && !bus.ld_we) begin
            w_tag_in = TAG_LD;
        end
    end

    always_comb begin
        w_wait_nxt = '0;
        if (w_ld_wait) begin
            w_wait_nxt = (r_wait == WAIT_SAT) ? r_wait : r_wait + WAIT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_addrb      <= '0;
            r_web        <= 1'b0;
            r_dinb       <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                r_tag[i] <= TAG_NONE;
            end
            r_vga_rvalid <= 1'b0;
            r_vga_rdata  <= '0;
            r_ld_rvalid  <= 1'b0;
            r_ld_rdata   <= '0;
            r_wait       <= '0;
            r_starve     <= 1'b0;
        end else begin
            if (w_vga_gnt) begin
                r_addrb <= bus.vga_addr;
                r_web   <= 1'b0;
            end else if (w_ld_gnt) begin
                r_addrb <= bus.ld_addr;
                r_web   <= bus.ld_we;
                r_dinb  <= bus.ld_wdata;
            end else begin
                r_web   <= 1'b0;
            end

            // The last stage lines up with doutb being valid for the read that owns it.
            r_tag[0] <= w_tag_in;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_vga_rvalid <= (r_tag[RD_LAT] == TAG_VGA);
            r_ld_rvalid  <= (r_tag[RD_LAT] == TAG_LD);
            if (r_tag[RD_LAT] == TAG_VGA) begin
                r_vga_rdata <= bus.doutb;
            end
            if (r_tag[RD_LAT] == TAG_LD) begin
                r_ld_rdata <= bus.doutb;
            end

            r_wait   <= w_wait_nxt;
            r_starve <= (32'(w_wait_nxt) >= MAX_WAIT_U);
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_grants;
    logic [31:0] r_stat_denied;

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_stat_grants <= '0;
            r_stat_denied <= '0;
        end else begin
            if (w_ld_gnt) begin
                r_stat_grants <= r_stat_grants + 32'd1;
            end
            if (w_ld_wait) begin
                r_stat_denied <= r_stat_denied + 32'd1;
            end
        end
    end

    assign stat_ld_grants = r_stat_grants;
    assign stat_ld_denied = r_stat_denied;
`endif

    assign bus.ld_gnt     = w_ld_gnt;
    assign bus.addrb      = r_addrb;
    assign bus.web        = r_web;
    assign bus.dinb       = r_dinb;
    assign bus.vga_rvalid = r_vga_rvalid;
    assign bus.vga_rdata  = r_vga_rdata;
    assign bus.ld_rvalid  = r_ld_rvalid;
    assign bus.ld_rdata   = r_ld_rdata;
    assign bus.ld_starve  = r_starve;

endmodule

// File: doc/vga_bram_arbiter.md
Name: vga_bram_arbiter

Overview:
- Shares the single 16-bit image-RAM port (addrb/doutb side of the display path) between two requesters: the VGA scanout fetch and the cover-art/UI loader.
- Scanout has absolute priority because it cannot stall. The loader is served on idle cycles and is tracked for starvation.
- Sits between vga timing/pixel logic and the BRAM port B. It registers the port controls and routes read data back to the requester that issued each read.

Parameters:
- ADDR_W, 15, BRAM address width
- DATA_W, 16, BRAM data width
- RD_LAT, 1, BRAM read latency in cycles from the addrb edge to valid doutb (1..4)
- WAIT_W, 8, width of the loader wait counter
- MAX_WAIT, 200, wait cycles at which ld_starve asserts

Ports:
- CLK  in  1  system clock
- RST_BTN  in  1  asynchronous active-low reset
- vga_req  in  1  scanout read request, one word per cycle
- vga_addr  in  ADDR_W  scanout read address
- vga_rvalid  out  1  scanout read data valid (1-cycle pulse)
- vga_rdata  out  DATA_W  scanout read data
- ld_req  in  1  loader request
- ld_we  in  1  loader write enable (1 = write, 0 = read)
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader request accepted this cycle (combinational)
- ld_rvalid  out  1  loader read data valid (1-cycle pulse)
- ld_rdata  out  DATA_W  loader read data
- ld_starve  out  1  loader waited for at least MAX_WAIT cycles
- addrb  out  ADDR_W  BRAM address (registered)
- web  out  1  BRAM write enable (registered)
- dinb  out  DATA_W  BRAM write data (registered)
- doutb  in  DATA_W  BRAM read data

Behaviour:
- Reset, async on RST_BTN=0: addrb, web, dinb, vga_rdata and ld_rdata are 0. vga_rvalid, ld_rvalid and ld_starve are 0. The tag pipeline and the wait counter are cleared. Reads in flight at reset are discarded and never produce an rvalid.
- Arbitration each cycle uses fixed priority: vga_req, then ld_req, then idle.
- ld_gnt = ld_req & ~vga_req. A loader transfer occurs when ld_req & ld_gnt at a rising edge. The loader holds its request stable until granted.
- On a VGA grant edge: addrb <= vga_addr; web <= 0; a tag VGA enters the pipeline.
- On a loader grant edge: addrb <= ld_addr; web <= ld_we; dinb <= ld_wdata. A tag LD enters the pipeline only if ld_we = 0.
- On an idle edge: web <= 0; addrb and dinb hold their values; tag NONE enters the pipeline.
- Tag pipeline is RD_LAT+1 stages deep. When a tag exits, doutb is captured into the matching rdata register and the matching rvalid pulses for 1 cycle. Total latency: acceptance at edge E gives rvalid high after edge E+RD_LAT+1.
- rdata registers hold their last value when rvalid = 0. Writes never produce an rvalid.
- Back-to-back requests from either side are accepted every cycle. Returns appear in issue order with no bubbles.
- Wait counter: increments on each edge where ld_req & ~ld_gnt, saturating at 2^WAIT_W-1. It clears on a loader grant or when ld_req = 0.
- ld_starve is registered: 1 when the wait counter is >= MAX_WAIT, and clears on the edge following a grant.
- Same-address conflict (scanout reads X while the loader wants to write X): VGA wins and the write waits. Ordering between the two is defined by grant order only.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds two 32-bit output ports, stat_ld_grants and stat_ld_denied. They count loader grants and denied cycles (ld_req & ~ld_gnt) and wrap at 2^32.
- Both counters are cleared by reset.
- When the macro is undefined, the ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset with RST_BTN=0 mid-stream, 2 VGA reads in flight -> all outputs 0 immediately; no rvalid after release.
- VGA-only read sweep, addr 0..7 every cycle, RD_LAT=1 -> vga_rvalid high 2 cycles after the first request; vga_rdata equals BRAM contents at 0..7 in order, no gaps.
- Loader write 0x1234 to addr 100 with VGA idle -> ld_gnt=1 same cycle; addrb=100, web=1, dinb=0x1234 after the edge; no ld_rvalid. Loader read of 100 returns 0x1234 after 2 cycles.
- Interleaved traffic: VGA reads on cycles 0-2 and 5; loader read requested on cycle 1 -> ld_gnt only on cycle 3; vga_rvalid and ld_rvalid never asserted on the same tag; data routed correctly.
- Starvation: vga_req held high for 250 cycles with ld_req=1, MAX_WAIT=200 -> ld_starve rises after wait count 200; loader granted on the first vga_req=0 cycle; ld_starve clears on the next edge.
- ARB_STATS_EN defined, previous scenario -> stat_ld_denied=250, stat_ld_grants=1.
